// File: rtl/predictor_update_queue_if.sv
// Bus bundle for predictor_update_queue.
//   enq*  : per-lane update requests from commit (lane index = age, higher is younger)
//   wr*   : head entry toward the predictor RAM write port
//   lk*   : fetch-side lookup of pending data
//   count / dropCount : occupancy and saturating drop statistics
// master = commit/fetch/RAM side, slave = the queue itself.
interface predictor_update_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ENQ_PORTS  = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ENQ_PORTS-1:0]            enqValid;
  logic [ENQ_PORTS*ADDR_WIDTH-1:0] enqAddr;
  logic [ENQ_PORTS*DATA_WIDTH-1:0] enqData;
  logic                            enqReady;
  logic                            wrValid;
  logic [ADDR_WIDTH-1:0]           wrAddr;
  logic [DATA_WIDTH-1:0]           wrData;
  logic                            wrReady;
  logic [ADDR_WIDTH-1:0]           lkAddr;
  logic                            lkHit;
  logic [DATA_WIDTH-1:0]           lkData;
  logic [CNT_W-1:0]                count;
  logic [15:0]                     dropCount;

  modport master (
    output enqValid, enqAddr, enqData, wrReady, lkAddr,
    input  enqReady, wrValid, wrAddr, wrData, lkHit, lkData, count, dropCount
  );

  modport slave (
    input  enqValid, enqAddr, enqData, wrReady, lkAddr,
    output enqReady, wrValid, wrAddr, wrData, lkHit, lkData, count, dropCount
  );
endinterface

// File: rtl/predictor_update_queue.sv
// Deferred-write queue for branch-predictor table updates (PHT counters, BTB entries).
// Buffers multi-lane commit updates, optionally coalescing same-address updates,
// and drains one entry per cycle into the table's single write port. A lookup
// CAM forwards pending data to the fetch-stage predictor read.
// Ports: clk, rst (sync, active-high), flush (drop all pending entries),
//        bus (predictor_update_queue_if.slave: enq lanes, wr head, lookup, stats).
module predictor_update_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ENQ_PORTS  = 2,
  parameter int unsigned COALESCE   = 1
) (
  input logic clk,
  input logic rst,
  input logic flush,
  predictor_update_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]      entValid;
  logic [ADDR_WIDTH-1:0] entAddr [DEPTH];
  logic [DATA_WIDTH-1:0] entData [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [15:0]           dropCnt;

  logic                  enqReadyC;
  logic                  wrValidC;
  logic                  popC;

  logic [ENQ_PORTS-1:0]  laneWrite;
  logic [PTR_W-1:0]      laneIdx  [ENQ_PORTS];
  logic [DATA_WIDTH-1:0] laneData [ENQ_PORTS];
  logic [CNT_W-1:0]      allocs;
  logic [2:0]            dropNum;

  logic                  lkHitC;
  logic [DATA_WIDTH-1:0] lkDataC;

  // Readiness uses registered count only, so no wrReady -> enqReady path.
  assign enqReadyC = (count <= CNT_W'(DEPTH - ENQ_PORTS));
  assign wrValidC  = (count != '0) && !flush;
  assign popC      = wrValidC && bus.wrReady;

  // Per-lane decision: drop, merge into a pending entry, or allocate at tail.
  // The oldest lane of a same-address group owns the slot; it carries the
  // youngest lane's data so the group writes once.
  always_comb begin
    logic                  lead;
    logic                  hit;
    logic [PTR_W-1:0]      hitIdx;
    logic [ADDR_WIDTH-1:0] addrI;
    laneWrite = '0;
    allocs    = '0;
    dropNum   = '0;
    for (int i = 0; i < ENQ_PORTS; i++) begin
      laneIdx[i]  = '0;
      laneData[i] = bus.enqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < ENQ_PORTS; i++) begin
      lead   = 1'b1;
      hit    = 1'b0;
      hitIdx = '0;
      addrI  = bus.enqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (COALESCE != 0) begin
        for (int j = 0; j < i; j++) begin
          if (bus.enqValid[j] && bus.enqAddr[j*ADDR_WIDTH +: ADDR_WIDTH] == addrI) lead = 1'b0;
        end
        for (int j = i + 1; j < ENQ_PORTS; j++) begin
          if (bus.enqValid[j] && bus.enqAddr[j*ADDR_WIDTH +: ADDR_WIDTH] == addrI)
            laneData[i] = bus.enqData[j*DATA_WIDTH +: DATA_WIDTH];
        end
        // The entry leaving this cycle cannot absorb a merge.
        for (int k = 0; k < DEPTH; k++) begin
          if (entValid[k] && !(popC && PTR_W'(k) == head) && entAddr[k] == addrI) begin
            hit    = 1'b1;
            hitIdx = PTR_W'(k);
          end
        end
      end
      if (bus.enqValid[i] && !flush) begin
        if (!enqReadyC) begin
          dropNum = dropNum + 3'd1;
        end else if (lead) begin
          laneWrite[i] = 1'b1;
          if (hit) begin
            laneIdx[i] = hitIdx;
          end else begin
            laneIdx[i] = tail + PTR_W'(allocs);
            allocs     = allocs + CNT_W'(1);
          end
        end
      end
    end
  end

  // Lookup CAM: walk from head toward tail so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    lkHitC  = 1'b0;
    lkDataC = '0;
    for (int o = 0; o < DEPTH; o++) begin
      idx = head + PTR_W'(o);
      if (entValid[idx] && entAddr[idx] == bus.lkAddr) begin
        lkHitC  = 1'b1;
        lkDataC = entData[idx];
      end
    end
  end

  // State update: flush beats pop/enqueue; dropCount survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      entValid <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      dropCnt  <= '0;
    end else begin
      if (dropNum != '0) begin
        if ((17'(dropCnt) + 17'(dropNum)) > 17'h0FFFF) dropCnt <= 16'hFFFF;
        else dropCnt <= dropCnt + 16'(dropNum);
      end
      if (flush) begin
        entValid <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (popC) begin
          entValid[head] <= 1'b0;
          head           <= head + PTR_W'(1);
        end
        for (int i = 0; i < ENQ_PORTS; i++) begin
          if (laneWrite[i]) begin
            entValid[laneIdx[i]] <= 1'b1;
            entAddr[laneIdx[i]]  <= bus.enqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            entData[laneIdx[i]]  <= laneData[i];
          end
        end
        tail  <= tail + PTR_W'(allocs);
        count <= count + allocs - CNT_W'(popC);
      end
    end
  end

  assign bus.enqReady  = enqReadyC;
  assign bus.wrValid   = wrValidC;
  assign bus.wrAddr    = entAddr[head];
  assign bus.wrData    = entData[head];
  assign bus.lkHit     = lkHitC;
  assign bus.lkData    = lkDataC;
  assign bus.count     = count;
  assign bus.dropCount = dropCnt;
endmodule

// File: tb/tb_predictor_update_queue.sv
// Bench for predictor_update_queue: a coalescing instance and a non-coalescing
// instance share identical stimulus; a queue-level model of each is checked
// every cycle, plus literal expectations at key points.
module tb_predictor_update_queue;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 2;
  localparam int unsigned DEP = 32;
  localparam int unsigned ENQ = 2;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  d;
  } ent_t;
  typedef ent_t entQ_t[$];

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  enqValid;
  logic [63:0] enqAddr;
  logic [3:0]  enqData;
  logic        wrReady;
  logic [31:0] lkAddr;

  int nCmp  = 0;
  int nFail = 0;
  bit checkOn = 0;

  entQ_t q0, q1;
  int    dr0 = 0, dr1 = 0;

  predictor_update_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .ENQ_PORTS(ENQ)) ifc0 ();
  predictor_update_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .ENQ_PORTS(ENQ)) ifc1 ();

  assign ifc0.enqValid = enqValid;
  assign ifc0.enqAddr  = enqAddr;
  assign ifc0.enqData  = enqData;
  assign ifc0.wrReady  = wrReady;
  assign ifc0.lkAddr   = lkAddr;
  assign ifc1.enqValid = enqValid;
  assign ifc1.enqAddr  = enqAddr;
  assign ifc1.enqData  = enqData;
  assign ifc1.wrReady  = wrReady;
  assign ifc1.lkAddr   = lkAddr;

  predictor_update_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .ENQ_PORTS(ENQ), .COALESCE(1))
    u0 (.clk(clk), .rst(rst), .flush(flush), .bus(ifc0.slave));
  predictor_update_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .ENQ_PORTS(ENQ), .COALESCE(0))
    u1 (.clk(clk), .rst(rst), .flush(flush), .bus(ifc1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending updates as an age-ordered list; lanes applied one after another.
  function automatic void step(input bit co, input entQ_t qIn, input int drIn,
                               output entQ_t qOut, output int drOut);
    entQ_t       q = qIn;
    int          dr = drIn;
    int          nv;
    bit          ready;
    bit          found;
    logic [31:0] aa;
    logic [1:0]  dd;
    if (rst) begin
      q.delete();
      dr = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      ready = (DEP - q.size()) >= ENQ;
      if (q.size() != 0 && wrReady) void'(q.pop_front());
      if (!ready) begin
        nv = int'(enqValid[0]) + int'(enqValid[1]);
        dr = (dr + nv > 65535) ? 65535 : dr + nv;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (enqValid[i]) begin
            aa = enqAddr[i*32 +: 32];
            dd = enqData[i*2 +: 2];
            found = 0;
            if (co) begin
              foreach (q[k]) if (q[k].a == aa) begin q[k].d = dd; found = 1; end
            end
            if (!found) q.push_back('{a: aa, d: dd});
          end
        end
      end
    end
    qOut  = q;
    drOut = dr;
  endfunction

  always @(posedge clk) begin
    entQ_t n0, n1;
    int    m0, m1;
    step(1'b1, q0, dr0, n0, m0);
    step(1'b0, q1, dr1, n1, m1);
    q0 = n0; dr0 = m0;
    q1 = n1; dr1 = m1;
  end

  task automatic cmpDut(input string tag, input entQ_t q, input int dr,
                        input logic wv, input logic [31:0] wa, input logic [1:0] wd,
                        input logic er, input logic lh, input logic [1:0] ld,
                        input logic [5:0] cnt, input logic [15:0] dc);
    logic       expWv;
    logic       expLh = 1'b0;
    logic [1:0] expLd = 2'd0;
    expWv = (q.size() != 0) && !flush;
    check({tag, ".count"}, 64'(cnt), 64'(q.size()));
    check({tag, ".enqReady"}, 64'(er), 64'((DEP - q.size()) >= ENQ));
    check({tag, ".wrValid"}, 64'(wv), 64'(expWv));
    if (expWv) begin
      check({tag, ".wrAddr"}, 64'(wa), 64'(q[0].a));
      check({tag, ".wrData"}, 64'(wd), 64'(q[0].d));
    end
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].a == lkAddr) begin expLh = 1'b1; expLd = q[k].d; end
    end
    check({tag, ".lkHit"}, 64'(lh), 64'(expLh));
    check({tag, ".lkData"}, 64'(ld), 64'(expLd));
    check({tag, ".dropCount"}, 64'(dc), 64'(dr));
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      cmpDut("u0", q0, dr0, ifc0.wrValid, ifc0.wrAddr, ifc0.wrData, ifc0.enqReady,
             ifc0.lkHit, ifc0.lkData, ifc0.count, ifc0.dropCount);
      cmpDut("u1", q1, dr1, ifc1.wrValid, ifc1.wrAddr, ifc1.wrData, ifc1.enqReady,
             ifc1.lkHit, ifc1.lkData, ifc1.count, ifc1.dropCount);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic [1:0] v, input logic [31:0] a0, input logic [1:0] d0,
                       input logic [31:0] a1, input logic [1:0] d1, input logic wr);
    enqValid = v;
    enqAddr  = {a1, a0};
    enqData  = {d1, d0};
    wrReady  = wr;
  endtask

  task automatic idle(input logic wr);
    setIn(2'b00, 32'h0, 2'd0, 32'h0, 2'd0, wr);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    lkAddr = 32'h0;
    idle(1'b0);
    tick();
    checkOn = 1;
    tick();
    rst = 1'b0;
    #2;
    // Reset state
    check("rst.count", 64'(ifc0.count), 64'd0);
    check("rst.enqReady", 64'(ifc0.enqReady), 64'd1);
    check("rst.wrValid", 64'(ifc0.wrValid), 64'd0);
    check("rst.lkHit", 64'(ifc0.lkHit), 64'd0);
    check("rst.dropCount", 64'(ifc0.dropCount), 64'd0);

    // Basic FIFO: fill 32, then drain in order
    for (int c = 0; c < 16; c++) begin
      setIn(2'b11, 32'h1000 + 32'(2*c), 2'(c), 32'h1000 + 32'(2*c+1), 2'(c+1), 1'b0);
      tick();
    end
    idle(1'b0);
    #2;
    check("fifo.fullCount", 64'(ifc0.count), 64'd32);
    check("fifo.fullReady", 64'(ifc0.enqReady), 64'd0);
    check("fifo.headAddr", 64'(ifc0.wrAddr), 64'h1000);
    idle(1'b1);
    tick();
    #2;
    check("fifo.secondAddr", 64'(ifc0.wrAddr), 64'h1001);
    check("fifo.secondData", 64'(ifc0.wrData), 64'd1);
    repeat (31) tick();
    idle(1'b0);
    #2;
    check("fifo.emptyCount", 64'(ifc0.count), 64'd0);
    check("fifo.emptyValid", 64'(ifc0.wrValid), 64'd0);

    // Coalescing
    lkAddr = 32'h100;
    setIn(2'b01, 32'h100, 2'd1, 32'h0, 2'd0, 1'b0);
    tick();
    setIn(2'b01, 32'h100, 2'd3, 32'h0, 2'd0, 1'b0);
    tick();
    idle(1'b0);
    #2;
    check("coal.count", 64'(ifc0.count), 64'd1);
    check("coal.wrData", 64'(ifc0.wrData), 64'd3);
    check("coal.lkHit", 64'(ifc0.lkHit), 64'd1);
    check("coal.lkData", 64'(ifc0.lkData), 64'd3);
    check("nocoal.count", 64'(ifc1.count), 64'd2);
    check("nocoal.wrData", 64'(ifc1.wrData), 64'd1);
    setIn(2'b11, 32'h100, 2'd2, 32'h100, 2'd0, 1'b0);
    tick();
    idle(1'b0);
    #2;
    check("coal.sameCycleCount", 64'(ifc0.count), 64'd1);
    check("coal.sameCycleData", 64'(ifc0.wrData), 64'd0);
    check("nocoal.sameCycleCount", 64'(ifc1.count), 64'd4);
    idle(1'b1);
    repeat (4) tick();

    // Head-pop exclusion
    lkAddr = 32'h300;
    setIn(2'b01, 32'h300, 2'd1, 32'h0, 2'd0, 1'b0);
    tick();
    setIn(2'b01, 32'h300, 2'd2, 32'h0, 2'd0, 1'b1);
    tick();
    idle(1'b0);
    #2;
    check("pop.count", 64'(ifc0.count), 64'd1);
    check("pop.wrAddr", 64'(ifc0.wrAddr), 64'h300);
    check("pop.wrData", 64'(ifc0.wrData), 64'd2);
    idle(1'b1);
    tick();

    // Flush with concurrent enqueue and pop
    for (int c = 0; c < 5; c++) begin
      setIn(2'b11, 32'h2000 + 32'(2*c), 2'(c), 32'h2000 + 32'(2*c+1), 2'(c+2), 1'b0);
      tick();
    end
    setIn(2'b11, 32'h3000, 2'd1, 32'h3001, 2'd2, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(1'b0);
    #2;
    check("flush.count", 64'(ifc0.count), 64'd0);
    check("flush.wrValid", 64'(ifc0.wrValid), 64'd0);
    check("flush.dropCount", 64'(ifc0.dropCount), 64'd0);

    // Drop at count 31
    for (int c = 0; c < 15; c++) begin
      setIn(2'b11, 32'h5000 + 32'(2*c), 2'(c), 32'h5000 + 32'(2*c+1), 2'(c+1), 1'b0);
      tick();
    end
    setIn(2'b01, 32'h5100, 2'd1, 32'h0, 2'd0, 1'b0);
    tick();
    setIn(2'b11, 32'h5200, 2'd1, 32'h5201, 2'd2, 1'b0);
    tick();
    idle(1'b0);
    #2;
    check("drop.count", 64'(ifc0.count), 64'd31);
    check("drop.dropCount", 64'(ifc0.dropCount), 64'd2);
    check("drop.enqReady", 64'(ifc0.enqReady), 64'd0);
    idle(1'b1);
    repeat (31) tick();

    // Wrap with random back-pressure
    for (int c = 0; c < 20; c++) begin
      setIn(2'b11, 32'h4000 + 32'(2*c), 2'(c), 32'h4000 + 32'(2*c+1), 2'(c+3),
            1'($urandom_range(0, 1)));
      tick();
    end
    idle(1'b1);
    repeat (40) tick();

    // Duplicate addresses: youngest wins without coalescing
    lkAddr = 32'h200;
    setIn(2'b11, 32'h200, 2'd1, 32'h200, 2'd2, 1'b0);
    tick();
    idle(1'b0);
    #2;
    check("dup.u1count", 64'(ifc1.count), 64'd2);
    check("dup.u1lkData", 64'(ifc1.lkData), 64'd2);
    check("dup.u0count", 64'(ifc0.count), 64'd1);
    setIn(2'b01, 32'h200, 2'd3, 32'h0, 2'd0, 1'b0);
    tick();
    idle(1'b0);
    #2;
    check("dup.u1young", 64'(ifc1.lkData), 64'd3);
    check("dup.u1hit", 64'(ifc1.lkHit), 64'd1);

    // Saturating drop counter
    for (int c = 0; c < 16; c++) begin
      setIn(2'b11, 32'h7000 + 32'(2*c), 2'd1, 32'h7000 + 32'(2*c+1), 2'd2, 1'b0);
      tick();
    end
    setIn(2'b11, 32'h8000, 2'd1, 32'h8001, 2'd2, 1'b0);
    repeat (32768) tick();
    idle(1'b0);
    #2;
    check("sat.u0dropCount", 64'(ifc0.dropCount), 64'hFFFF);
    check("sat.u1dropCount", 64'(ifc1.dropCount), 64'hFFFF);

    // Reset in the middle of traffic
    setIn(2'b11, 32'h6000, 2'd1, 32'h6001, 2'd2, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lkAddr = 32'h6000;
    idle(1'b0);
    #2;
    check("midrst.count", 64'(ifc0.count), 64'd0);
    check("midrst.wrValid", 64'(ifc0.wrValid), 64'd0);
    check("midrst.lkHit", 64'(ifc0.lkHit), 64'd0);
    check("midrst.lkData", 64'(ifc0.lkData), 64'd0);
    check("midrst.enqReady", 64'(ifc0.enqReady), 64'd1);
    check("midrst.dropCount", 64'(ifc0.dropCount), 64'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule

// File: doc/predictor_update_queue.md
# predictor_update_queue

Parametrised deferred-write queue that buffers branch-predictor table updates, such as PHT counters or BTB entries, until the table's single write port is free. It is the generalised successor of the fixed 32-entry, single-lane PHT/BTB queues. It adds:
- configurable depth and widths;
- multiple enqueue lanes per cycle, one per commit lane;
- same-address coalescing;
- a lookup port that forwards pending data to the fetch-stage predictor read.

It sits between the branch-resolution/commit logic and the predictor RAM write port.

## Interface
Parameters:
- ADDR_WIDTH, 32: table write-address width, matching AddrPath.
- DATA_WIDTH, 2: entry payload width. 2 is a PHT counter; BTB users set the BTB entry width.
- DEPTH, 32: number of entries. Must be a power of two and ≥ 4.
- ENQ_PORTS, 2: number of enqueue lanes. Must be 1..4 and ≤ DEPTH.
- COALESCE, 1: 1 enables same-address merging; 0 makes every valid enqueue allocate an entry.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all pending entries.
- enqValid  in  ENQ_PORTS  per-lane update request. Lane index order is age order, so a higher index is younger.
- enqAddr  in  ENQ_PORTS×ADDR_WIDTH  per-lane table address.
- enqData  in  ENQ_PORTS×DATA_WIDTH  per-lane new value.
- enqReady  out  1  all lanes may enqueue this cycle.
- wrValid  out  1  head entry is available for the table write.
- wrAddr  out  ADDR_WIDTH  head address.
- wrData  out  DATA_WIDTH  head data.
- wrReady  in  1  the table write port accepts the head this cycle.
- lkAddr  in  ADDR_WIDTH  fetch-side lookup address.
- lkHit  out  1  a pending entry matches lkAddr.
- lkData  out  DATA_WIDTH  data of the matching entry.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- dropCount  out  16  saturating count of dropped lane updates.

## Operation
- **Storage:** circular buffer of {valid, addr, data} with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- **enqReady:** `(DEPTH − count) ≥ ENQ_PORTS`, computed from registered count only. It does not credit a same-cycle pop, so there is no path from wrReady to enqReady.
- **Drop rule:** if enqReady=0, every valid lane is dropped. dropCount increments by the number of valid lanes and saturates at 0xFFFF. The queue state is unchanged by the drop. Predictor updates are hints, so losing them is acceptable.
- **Coalescing (COALESCE=1):**
  - A valid lane whose address matches a valid pending entry overwrites that entry's data in place. The entry keeps its queue position.
  - An entry being popped this cycle (wrValid & wrReady) is excluded from matching, so the lane allocates a new entry instead.
  - Lanes sharing an address within one cycle allocate or merge once, using the data from the highest-index lane.
- **Allocation:** non-merged lanes allocate at tail, tail+1, … in lane order. Then `tail += allocs`.
- **Dequeue:** wrValid = (count ≠ 0) & ~flush. wrAddr and wrData come from the head entry. On wrValid & wrReady, the head is invalidated and head advances by 1.
- **Count update:** `count_next = count + allocs − pop`.
- **Lookup:** combinational CAM over valid, registered entries. Same-cycle enqueues are not visible to it.
  - If several entries match (possible only with COALESCE=0), the youngest one wins, i.e. the one nearest tail.
  - If nothing matches, lkHit=0 and lkData=0.
- **Flush:**
  - Clears all valid bits, head, tail and count in the next state.
  - Has priority over enqueue and pop in the same cycle. Enqueues in that cycle are discarded and not counted as drops.
  - dropCount is preserved.
- **Reset:** head=tail=count=0, all valid bits=0, dropCount=0. Outputs after reset: wrValid=0, lkHit=0, lkData=0, count=0, enqReady=1.

## Timing
- Enqueue into an empty queue at cycle N makes wrValid=1 at N+1, with that entry's addr and data.
- Coalesced data is visible on wrData and lkData at N+1.
- Pop at cycle N presents the next entry, or wrValid=0, at N+1.
- A simultaneous pop and enqueue at count=DEPTH−ENQ_PORTS is legal. count_next = count + allocs − 1.
- rst or flush asserted mid-stream empties the queue at the next edge; wrValid=0 from the following cycle.
- Pointer wrap: an allocation spanning index DEPTH−1 → 0 must store lane order correctly.

## Test plan
- **Basic FIFO:** DEPTH=32, ENQ_PORTS=2, wrReady=0. Enqueue 16 cycles of distinct address pairs → count=32, enqReady=0. Then wrReady=1 → 32 pops in enqueue order, with lane 0 before lane 1.
- **Coalescing:** enqueue A=0x100/data 1, then A/data 3 with wrReady=0 → count=1, wrData=3, lkHit=1 for lkAddr=0x100. Same-cycle lanes both A with data 2 (lane 0) and data 0 (lane 1) → one entry holding 0.
- **Head-pop exclusion:** single entry A, wrReady=1, enqueue A/data 2 the same cycle → A is popped and a new A/2 entry is allocated; count stays 1.
- **Drop and saturation:** fill to count=31 with ENQ_PORTS=2, then 2 valid lanes → both dropped, count=31, dropCount=2. Forcing 0xFFFF more drops → dropCount holds at 0xFFFF.
- **Wrap:** cycle 40 entries through DEPTH=32 with random wrReady, and compare wrAddr/wrData against a reference FIFO model. With COALESCE=0 and duplicate addresses, check that lkData returns the youngest duplicate.
- **Flush and reset:** with count=10, assert flush together with 2 enqueues and wrReady=1 → count=0 and wrValid=0 at the next cycle, dropCount unchanged. rst mid-traffic → all outputs at their reset values.
